// File: rtl/accumulator_pkg.sv
// accumulator_pkg: shared widths, read FSM encoding and flat-bus column helper
// for the accumulator read and write paths.
package accumulator_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_e;

    function automatic int psum_width(int weight_w, int act_w, int size);
        return weight_w + act_w + $clog2(size);
    endfunction

    function automatic int addr_width(int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

    // LSB of column i inside a flat bus of width-w columns
    function automatic int col_lsb(int i, int w);
        return i * w;
    endfunction

endpackage

// File: rtl/acc_rd_fifo.sv
// acc_rd_fifo: first-word-fall-through FIFO over registered storage,
// exposing its occupancy so the reader can meter reads against free space.
module acc_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr, wptr;
    logic             do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop & valid;
    assign valid  = count != '0;
    assign dout   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= din;
                wptr      <= inc(wptr);
            end
            if (do_pop) rptr <= inc(rptr);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count == CW'(DEPTH) && !do_pop));

endmodule

// File: rtl/accumulator_reader.sv
// accumulator_reader: bursts row reads from the column memories and streams
// the returned rows downstream through a credit-metered output FIFO.
module accumulator_reader
    import accumulator_pkg::*;
#(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int WEIGHT_WIDTH      = 8,
    parameter int ACTIVATION_WIDTH  = 8,
    parameter int PARTIAL_SUM_WIDTH = psum_width(WEIGHT_WIDTH, ACTIVATION_WIDTH, SYSTOLIC_SIZE),
    parameter int PATTERN_NUMBER    = 1,
    parameter int DEPTH             = PATTERN_NUMBER * SYSTOLIC_SIZE,
    parameter int ADDR_WIDTH        = addr_width(DEPTH),
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [ADDR_WIDTH-1:0]                       start_addr,
    input  logic [ADDR_WIDTH:0]                         num_rows,
    output logic                                        rd_en,
    output logic [ADDR_WIDTH-1:0]                       rd_addr,
    input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0]  rd_data_flat,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0]  out_data_flat,
    output logic [ADDR_WIDTH-1:0]                       out_addr,
    output logic                                        out_last,
    output logic                                        busy,
    output logic                                        done
);
    localparam int DW = PARTIAL_SUM_WIDTH * SYSTOLIC_SIZE;
    localparam int FW = DW + ADDR_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    rd_state_e             state;
    logic [ADDR_WIDTH-1:0] addr, rd_addr_q;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  rd_last, rd_en_q, rd_last_q, pop, can_issue;
    logic [CW-1:0]         fifo_count;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return a == ADDR_WIDTH'(DEPTH - 1) ? '0 : a + 1'b1;
    endfunction

    assign pop = out_valid & out_ready;
    // Reads still on their way (rd_en now, rd_en_q landing this edge) count as occupied slots.
    assign can_issue = 32'(fifo_count) + 32'(rd_en) + 32'(rd_en_q) < 32'(FIFO_DEPTH) + 32'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            rd_last   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_last_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            rd_en     <= 1'b0;
            done      <= 1'b0;
            rd_en_q   <= rd_en;
            rd_addr_q <= rd_addr;
            rd_last_q <= rd_last;
            case (state)
                IDLE: if (start && !done) begin
                    if (num_rows == '0) begin
                        done <= 1'b1;
                    end else begin
                        state     <= num_rows == 1 ? DRAIN : ISSUE;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_addr   <= start_addr;
                        rd_last   <= num_rows == 1;
                        addr      <= next_addr(start_addr);
                        remaining <= num_rows - 1'b1;
                    end
                end
                ISSUE: if (can_issue) begin
                    state     <= remaining == 1 ? DRAIN : ISSUE;
                    rd_en     <= 1'b1;
                    rd_addr   <= addr;
                    rd_last   <= remaining == 1;
                    addr      <= next_addr(addr);
                    remaining <= remaining - 1'b1;
                end
                DRAIN: if (pop && out_last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    acc_rd_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_en_q),
        .din   ({rd_data_flat, rd_addr_q, rd_last_q}),
        .pop   (pop),
        .dout  ({out_data_flat, out_addr, out_last}),
        .valid (out_valid),
        .count (fifo_count)
    );

endmodule
